game_timer_bcd: RTL and testbench
=================================

# game_timer_bcd

Elapsed-time counter for the minesweeper game. It sits between the game control logic and the 7-segment multiplexer: it starts on the level-select pulse, stops on explosion or win, and drives four BCD digits straight into the display mux's hex3..hex0 inputs. All state is in the VGA pixel clock domain, so no CDC logic is needed.

## Interface
- CLK_HZ, 65_000_000, frequency of clk in Hz; the prescaler divides by exactly this value to make a 1 s tick. Must be ≥ 2.

- clk  input  1  pixel clock, same clock as the board/mouse stages.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse (level chosen / enable_game rising edge); clears and (re)starts the timer.
- stop  input  1  level; freezes the timer while in RUN (tie to explode OR win).
- hex3  output  4  most significant BCD digit.
- hex2  output  4  BCD digit.
- hex1  output  4  BCD digit.
- hex0  output  4  least significant BCD digit.
- running  output  1  high while in RUN.
- overflow  output  1  sticky flag: the counter reached its maximum and saturated.

## Operation
- FSM states:
  - IDLE: reset state; digits at 0.
  - RUN: counting.
  - HALT: digits frozen.
- Transitions:
  - Any state + start → RUN. Digits, prescaler and overflow are cleared.
  - RUN + stop (start low) → HALT.
  - RUN + tick reaching the maximum → HALT, overflow=1.
  - HALT stays in HALT until start.
  - stop has no effect in IDLE or HALT.
- Prescaler: a ceil(log2(CLK_HZ))-bit counter that runs only in RUN.
  - Counts 0..CLK_HZ-1, then wraps to 0. The wrap cycle is the tick.
  - Held at 0 outside RUN.
- Digit increment on tick: ripple-carry BCD.
  - Each digit counts 0..9. Digit 9 → 0 and carries into the next digit.
  - Digit values are never outside 0..9.
- Maximum (without the macro): 9999. A tick at 9999 leaves the digits at 9999, sets overflow and goes to HALT.
- Priority:
  - start over stop.
  - stop over tick: when stop is high in the same cycle as a tick, there is no increment.
- Reset values: hex3..hex0=0, running=0, overflow=0, state IDLE, prescaler 0.

## Timing
- All outputs are registered. No combinational path from input to output.
- start sampled high at edge E0:
  - after E0: running=1 and digits=0.
  - The first increment is visible after edge E0+CLK_HZ. Each further increment follows every CLK_HZ cycles.
- stop sampled high at edge Es while in RUN: running=0 after Es. Digits keep the value they held before Es.
- start during RUN restarts from 0 with the prescaler phase reset. A partial second is discarded.
- Asserting rst mid-count forces the reset values asynchronously. After release, the block stays in IDLE until start.

## Configuration
- GAME_TIMER_MMSS_EN defined: minutes:seconds format.
  - hex3:hex2 = minutes 00..99.
  - hex1 counts 0..5 and hex0 counts 0..9 (seconds 00..59).
  - A tick at 59 seconds zeroes the seconds and increments the minutes.
  - Maximum is 99:59. Saturation rules are the same as the decimal mode.
- Undefined: plain 4-digit decimal seconds 0000..9999.

## Test plan
- Reset check (CLK_HZ=4): assert rst mid-count at value 0003 → outputs 0/0/0/0, running=0, overflow=0 immediately, before the next clk edge. Release rst → still IDLE, no counting.
- Count (CLK_HZ=4): start pulse, run 40 cycles → digits 0010, running=1. The first change to 0001 occurs exactly 4 cycles after the start edge.
- Carry chain (CLK_HZ=4): count to 0099, then one tick → 0100. Count to 0999, then one tick → 1000. No digit ever exceeds 9.
- Stop/priority (CLK_HZ=4):
  - Assert stop on the cycle the 0005→0006 tick would occur → digits hold 0005, running=0.
  - start and stop high in the same cycle → RUN, digits 0000.
- Saturation (CLK_HZ=2):
  - Decimal mode: run to 9999, then one more tick → hold 9999, overflow=1, HALT.
  - Restart with start → 0000, overflow=0.
- MMSS build (GAME_TIMER_MMSS_EN, CLK_HZ=2):
  - 00:59 + tick → 01:00.
  - 99:59 + tick → hold 99:59, overflow=1.

Source files
------------

// File: rtl/game_timer_bcd.sv
// -----------------------------------------------------------------------------
// game_timer_bcd
//   Elapsed-time counter for the minesweeper game. A start pulse clears and
//   (re)starts the count; stop freezes it. Four BCD digits feed the 7-segment
//   display mux directly. Single clock domain (VGA pixel clock).
//
//   Optional build macro: GAME_TIMER_MMSS_EN
//     undefined : plain decimal seconds 0000..9999
//     defined   : minutes:seconds, hex3:hex2 = 00..99, hex1:hex0 = 00..59
//
// Parameters
//   CLK_HZ    clk frequency in Hz; the prescaler divides by exactly this (>= 2)
//
// Ports
//   clk       pixel clock
//   rst       asynchronous, active-high reset
//   start     single-cycle pulse: clear everything and enter RUN (any state)
//   stop      level: RUN -> HALT (ignored in IDLE/HALT, loses to start)
//   hex3..0   BCD digits, hex3 most significant
//   running   high while in RUN (state visibility for checkers)
//   overflow  sticky: the count saturated at its maximum
//
// Input protocol: there is no handshake. start is sampled on every rising
//   edge and acts on each cycle it is high; stop is a level sampled on every
//   rising edge. All outputs are registered.
// -----------------------------------------------------------------------------
module game_timer_bcd #(
  parameter int CLK_HZ = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic       running,
  output logic       overflow
);

  localparam int            PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

`ifdef GAME_TIMER_MMSS_EN
  // Tens-of-seconds digit wraps after 5 so the low pair reads 00..59.
  localparam logic [3:0] D1_LAST = 4'd5;
`else
  localparam logic [3:0] D1_LAST = 4'd9;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

  logic          tick;
  logic          at_max;
  logic [3:0]    n3, n2, n1, n0;

  // The prescaler wrap cycle is the 1 s tick.
  assign tick   = (presc == PRESC_LAST);
  assign at_max = (hex3 == 4'd9) && (hex2 == 4'd9) &&
                  (hex1 == D1_LAST) && (hex0 == 4'd9);

  // Ripple-carry BCD increment of the current digits.
  always_comb begin
    n0 = hex0 + 4'd1;
    n1 = hex1;
    n2 = hex2;
    n3 = hex3;
    if (hex0 == 4'd9) begin
      n0 = 4'd0;
      n1 = hex1 + 4'd1;
      if (hex1 == D1_LAST) begin
        n1 = 4'd0;
        n2 = hex2 + 4'd1;
        if (hex2 == 4'd9) begin
          n2 = 4'd0;
          n3 = hex3 + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      hex3     <= 4'd0;
      hex2     <= 4'd0;
      hex1     <= 4'd0;
      hex0     <= 4'd0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else if (start) begin
      // start wins over stop and restarts the prescaler phase.
      state    <= RUN;
      presc    <= '0;
      hex3     <= 4'd0;
      hex2     <= 4'd0;
      hex1     <= 4'd0;
      hex0     <= 4'd0;
      running  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (stop) begin
            // stop wins over a coincident tick: digits keep their value.
            state   <= HALT;
            presc   <= '0;
            running <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            if (at_max) begin
              state    <= HALT;
              running  <= 1'b0;
              overflow <= 1'b1;
            end else begin
              hex3 <= n3;
              hex2 <= n2;
              hex1 <= n1;
              hex0 <= n0;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        HALT: begin
          presc   <= '0;
          running <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          presc   <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_timer_bcd.sv
// -----------------------------------------------------------------------------
// tb_game_timer_bcd
//   Two instances: dut_a with CLK_HZ=4 (counting, reset, carry, stop/priority)
//   and dut_b with CLK_HZ=2 (saturation, and the minutes:seconds corners when
//   built with GAME_TIMER_MMSS_EN). The reference model tracks elapsed RUN
//   cycles since the last start and derives seconds = cycles / CLK_HZ,
//   clamped at the maximum; digits come from plain decimal arithmetic.
// -----------------------------------------------------------------------------
module tb_game_timer_bcd;

  localparam int HZ_A = 4;
  localparam int HZ_B = 2;

`ifdef GAME_TIMER_MMSS_EN
  localparam int          MAX_S  = 99 * 60 + 59;
  localparam logic [15:0] C_99   = 16'h0139;
  localparam logic [15:0] C_100  = 16'h0140;
  localparam logic [15:0] C_999  = 16'h1639;
  localparam logic [15:0] C_1000 = 16'h1640;
`else
  localparam int          MAX_S  = 9999;
  localparam logic [15:0] C_99   = 16'h0099;
  localparam logic [15:0] C_100  = 16'h0100;
  localparam logic [15:0] C_999  = 16'h0999;
  localparam logic [15:0] C_1000 = 16'h1000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 1'b0, stop_a = 1'b0;
  logic start_b = 1'b0, stop_b = 1'b0;
  wire [15:0] dig_a, dig_b;
  wire        run_a, run_b, ovf_a, ovf_b;

  int checks   = 0;
  int failures = 0;

  game_timer_bcd #(.CLK_HZ(HZ_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a),
    .hex3(dig_a[15:12]), .hex2(dig_a[11:8]), .hex1(dig_a[7:4]), .hex0(dig_a[3:0]),
    .running(run_a), .overflow(ovf_a)
  );

  game_timer_bcd #(.CLK_HZ(HZ_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b),
    .hex3(dig_b[15:12]), .hex2(dig_b[11:8]), .hex1(dig_b[7:4]), .hex0(dig_b[3:0]),
    .running(run_b), .overflow(ovf_b)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_digits(input int s);
`ifdef GAME_TIMER_MMSS_EN
    int m, sec;
    m   = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
`else
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
`endif
  endfunction

  // ---------------- reference model ----------------
  // m_run: counting; m_n: RUN cycles since last start; m_ovf: saturated.
  logic m_run[2];
  logic m_ovf[2];
  int   m_n[2];
  logic mst, msp;
  int   mhz;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 1'b0;
      m_ovf[i] = 1'b0;
      m_n[i]   = 0;
    end
  end

  function automatic int model_secs(input int i);
    int h, s;
    h = (i == 0) ? HZ_A : HZ_B;
    s = m_n[i] / h;
    return (s > MAX_S) ? MAX_S : s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 1'b0;
        m_ovf[i] = 1'b0;
        m_n[i]   = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mst = (i == 0) ? start_a : start_b;
        msp = (i == 0) ? stop_a  : stop_b;
        mhz = (i == 0) ? HZ_A    : HZ_B;
        if (mst) begin
          m_run[i] = 1'b1;
          m_ovf[i] = 1'b0;
          m_n[i]   = 0;
        end else if (m_run[i]) begin
          if (msp) begin
            m_run[i] = 1'b0;
          end else begin
            m_n[i] = m_n[i] + 1;
            if (m_n[i] / mhz > MAX_S) begin
              m_run[i] = 1'b0;
              m_ovf[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("a.digits",   {16'd0, dig_a}, {16'd0, to_digits(model_secs(0))});
    check("a.running",  {31'd0, run_a},  {31'd0, m_run[0]});
    check("a.overflow", {31'd0, ovf_a},  {31'd0, m_ovf[0]});
    check("b.digits",   {16'd0, dig_b}, {16'd0, to_digits(model_secs(1))});
    check("b.running",  {31'd0, run_b},  {31'd0, m_run[1]});
    check("b.overflow", {31'd0, ovf_b},  {31'd0, m_ovf[1]});
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge right after the edge that sampled start.
  task automatic pulse_start(input int u, input logic with_stop);
    @(negedge clk);
    if (u == 0) begin start_a = 1'b1; stop_a = with_stop; end
    else        begin start_b = 1'b1; stop_b = with_stop; end
    @(negedge clk);
    if (u == 0) begin start_a = 1'b0; stop_a = 1'b0; end
    else        begin start_b = 1'b0; stop_b = 1'b0; end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    check("a.reset_digits", {16'd0, dig_a}, 32'h0);
    check("a.reset_running", {31'd0, run_a}, 32'd0);
    check("a.reset_overflow", {31'd0, ovf_a}, 32'd0);

    // stop in IDLE does nothing
    stop_a = 1'b1;
    cyc(6);
    stop_a = 1'b0;
    check("a.idle_stop_digits", {16'd0, dig_a}, 32'h0);
    check("a.idle_stop_running", {31'd0, run_a}, 32'd0);

    // count: first increment exactly CLK_HZ edges after start
    pulse_start(0, 1'b0);
    check("a.start_digits", {16'd0, dig_a}, 32'h0);
    check("a.start_running", {31'd0, run_a}, 32'd1);
    cyc(3);
    check("a.pre_tick", {16'd0, dig_a}, 32'h0);
    cyc(1);
    check("a.first_tick", {16'd0, dig_a}, 32'h0001);
    cyc(36);
    check("a.count_40", {16'd0, dig_a}, 32'h0010);
    check("a.count_running", {31'd0, run_a}, 32'd1);

    // asynchronous reset mid-count at 0003
    pulse_start(0, 1'b0);
    cyc(13);
    check("a.before_rst", {16'd0, dig_a}, 32'h0003);
    #2 rst = 1'b1;
    #1;
    check("a.async_rst_digits", {16'd0, dig_a}, 32'h0);
    check("a.async_rst_running", {31'd0, run_a}, 32'd0);
    check("a.async_rst_overflow", {31'd0, ovf_a}, 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(20);
    check("a.after_rst_idle", {16'd0, dig_a}, 32'h0);
    check("a.after_rst_running", {31'd0, run_a}, 32'd0);

    // stop on the 0005->0006 tick edge wins over the tick
    pulse_start(0, 1'b0);
    cyc(23);
    check("a.before_stop", {16'd0, dig_a}, 32'h0005);
    stop_a = 1'b1;
    cyc(1);
    check("a.stop_hold", {16'd0, dig_a}, 32'h0005);
    check("a.stop_running", {31'd0, run_a}, 32'd0);
    stop_a = 1'b0;
    cyc(8);
    check("a.halt_frozen", {16'd0, dig_a}, 32'h0005);

    // start and stop together: start wins
    pulse_start(0, 1'b1);
    check("a.start_stop_digits", {16'd0, dig_a}, 32'h0);
    check("a.start_stop_running", {31'd0, run_a}, 32'd1);
    cyc(4);
    check("a.start_stop_counts", {16'd0, dig_a}, 32'h0001);

    // carry chain
    pulse_start(0, 1'b0);
    cyc(99 * HZ_A);
    check("a.carry_99", {16'd0, dig_a}, {16'd0, C_99});
    cyc(HZ_A);
    check("a.carry_100", {16'd0, dig_a}, {16'd0, C_100});
    cyc(899 * HZ_A);
    check("a.carry_999", {16'd0, dig_a}, {16'd0, C_999});
    cyc(HZ_A);
    check("a.carry_1000", {16'd0, dig_a}, {16'd0, C_1000});

`ifdef GAME_TIMER_MMSS_EN
    // minutes:seconds corners on dut_b
    pulse_start(1, 1'b0);
    cyc(59 * HZ_B);
    check("b.mmss_0059", {16'd0, dig_b}, 32'h0059);
    cyc(HZ_B);
    check("b.mmss_0100", {16'd0, dig_b}, 32'h0100);
    cyc((MAX_S - 60) * HZ_B);
    check("b.mmss_9959", {16'd0, dig_b}, 32'h9959);
    check("b.mmss_pre_ovf", {31'd0, ovf_b}, 32'd0);
    cyc(HZ_B);
    check("b.mmss_sat_digits", {16'd0, dig_b}, 32'h9959);
    check("b.mmss_sat_overflow", {31'd0, ovf_b}, 32'd1);
    check("b.mmss_sat_running", {31'd0, run_b}, 32'd0);
`else
    // decimal saturation on dut_b
    pulse_start(1, 1'b0);
    cyc(9999 * HZ_B);
    check("b.dec_9999", {16'd0, dig_b}, 32'h9999);
    check("b.dec_pre_ovf", {31'd0, ovf_b}, 32'd0);
    cyc(HZ_B);
    check("b.dec_sat_digits", {16'd0, dig_b}, 32'h9999);
    check("b.dec_sat_overflow", {31'd0, ovf_b}, 32'd1);
    check("b.dec_sat_running", {31'd0, run_b}, 32'd0);
`endif
    // saturated state holds; stop in HALT has no effect
    stop_b = 1'b1;
    cyc(6);
    stop_b = 1'b0;
    check("b.sat_hold_overflow", {31'd0, ovf_b}, 32'd1);

    // restart clears overflow
    pulse_start(1, 1'b0);
    check("b.restart_digits", {16'd0, dig_b}, 32'h0);
    check("b.restart_overflow", {31'd0, ovf_b}, 32'd0);
    check("b.restart_running", {31'd0, run_b}, 32'd1);
    cyc(HZ_B);
    check("b.restart_counts", {16'd0, dig_b}, 32'h0001);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
